// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment glyph reader: segment indices,
// glyph geometry, probe centre lookup, digit-to-mask table and FSM states.
package seg_pkg;

  localparam int NUM_SEG = 7;

  // Bit positions inside a mask {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyph box size and segment stroke thickness
  localparam int GLYPH_W = 80;
  localparam int GLYPH_H = 140;
  localparam int SEG_T   = 20;

  // Masks for digits 0..9, indexed by the digit value
  localparam logic [NUM_SEG-1:0] DIGIT_MASK [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } state_t;

  // Probe centre column, relative to the glyph box: middle of each stroke
  function automatic int probe_cx(input int seg);
    case (seg)
      SEG_A, SEG_D, SEG_G: return GLYPH_W / 2;
      SEG_B, SEG_C:        return GLYPH_W - SEG_T / 2;
      default:             return SEG_T / 2;
    endcase
  endfunction

  // Probe centre row, relative to the glyph box: vertical strokes are probed
  // halfway between the horizontal strokes they join
  function automatic int probe_cy(input int seg);
    case (seg)
      SEG_A:        return SEG_T / 2;
      SEG_G:        return GLYPH_H / 2;
      SEG_D:        return GLYPH_H - SEG_T / 2;
      SEG_B, SEG_F: return (SEG_T / 2 + GLYPH_H / 2) / 2;
      default:      return (GLYPH_H / 2 + GLYPH_H - SEG_T / 2) / 2;
    endcase
  endfunction

endpackage

// File: rtl/seg_mask_decode.sv
// Combinational decode of a 7-bit segment mask into a digit with
// legal / blank flags. Digit is 0 whenever the mask is not a legal glyph.
module seg_mask_decode
  import seg_pkg::*;
(
  input  logic [NUM_SEG-1:0] mask,
  output logic [3:0]         digit,
  output logic               legal,
  output logic               blank
);

  // Search the glyph table for an exact match
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a
    // non-matching mask would leave them unassigned and infer latches.
    digit = '0;
    legal = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (mask == DIGIT_MASK[n]) begin
        digit = 4'(n);
        legal = 1'b1;
      end
    end
  end

  assign blank = (mask == '0);

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a digit glyph back from the pixel stream: seven probe squares count
// lit pixels during a frame, a majority vote per probe forms the segment mask
// and the mask is decoded and published once per frame.
module seven_segment_reader
  import seg_pkg::*;
#(
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int PROBE  = 4,
  parameter int STABLE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         sx,
  input  logic [9:0]         sy,
  input  logic               de,
  input  logic               pixel_on,
  input  logic               frame_start,
  input  logic               frame_end,
  output logic [NUM_SEG-1:0] seg_mask,
  output logic [3:0]         digit,
  output logic               valid,
  output logic               error,
  output logic               blank,
  output logic               locked
);

  localparam int AREA = PROBE * PROBE;
  localparam int CW   = $clog2(AREA + 1);
  localparam logic [CW-1:0] HIT_MAX    = CW'(AREA);
  localparam logic [CW-1:0] TH         = CW'(AREA / 2 + 1);
  localparam logic [3:0]    STABLE_MAX = 4'(STABLE);

  state_t              state;
  logic                start_pending;
  logic [CW-1:0]       hits [NUM_SEG];
  logic [NUM_SEG-1:0]  in_probe;
  logic [NUM_SEG-1:0]  mask_now;
  logic                clear_hits;
  logic                count_en;
  logic [3:0]          dec_digit;
  logic                dec_legal;
  logic                dec_blank;
  logic [3:0]          stable_cnt;
  logic [3:0]          stable_next;

  // Per-segment probe window test and majority vote
  for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
    localparam int XL = X0 + probe_cx(i) - PROBE / 2;
    localparam int YL = Y0 + probe_cy(i) - PROBE / 2;

    assign in_probe[i] = (int'(sx) >= XL) && (int'(sx) < XL + PROBE) &&
                         (int'(sy) >= YL) && (int'(sy) < YL + PROBE);
    assign mask_now[i] = (hits[i] >= TH);
  end

  // Counters restart whenever a frame (re)starts, including a start that was
  // deferred behind a same-cycle frame_end
  always_comb begin
    clear_hits = 1'b0;
    case (state)
      IDLE:    clear_hits = frame_start;
      SCAN:    clear_hits = frame_start && !frame_end;
      DECIDE:  clear_hits = frame_start || start_pending;
      default: clear_hits = 1'b0;
    endcase
  end

  assign count_en = (state == SCAN) && !clear_hits && de && pixel_on;

  // Frame FSM: IDLE -> SCAN -> DECIDE -> IDLE/SCAN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      start_pending <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block
      // sees the pre-edge values regardless of evaluation order.
      case (state)
        IDLE: begin
          if (frame_start) state <= SCAN;
        end
        SCAN: begin
          if (frame_end) begin
            state         <= DECIDE;
            start_pending <= frame_start;
          end
        end
        DECIDE: begin
          start_pending <= 1'b0;
          state         <= (frame_start || start_pending) ? SCAN : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating hit counters, one per probe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the counter array is a handful of flops, not RAM, so it is
      // reset like any other state; a mid-frame reset must discard counts.
      for (int i = 0; i < NUM_SEG; i++) hits[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        if (clear_hits) begin
          hits[i] <= '0;
        end else if (count_en && in_probe[i] && (hits[i] != HIT_MAX)) begin
          hits[i] <= hits[i] + 1'b1;
        end
      end
    end
  end

  seg_mask_decode u_decode (
    .mask  (mask_now),
    .digit (dec_digit),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // Next stability count: repeats of the same legal digit accumulate
  always_comb begin
    stable_next = '0;
    if (dec_legal) begin
      if (dec_digit != digit)             stable_next = 4'd1;
      else if (stable_cnt >= STABLE_MAX)  stable_next = STABLE_MAX;
      else                                stable_next = stable_cnt + 4'd1;
    end
  end

  // Publish the decision on the cycle after DECIDE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_mask   <= '0;
      digit      <= '0;
      valid      <= 1'b0;
      error      <= 1'b0;
      blank      <= 1'b0;
      locked     <= 1'b0;
      stable_cnt <= '0;
    end else begin
      valid <= 1'b0;
      if (state == DECIDE) begin
        seg_mask   <= mask_now;
        valid      <= 1'b1;
        blank      <= dec_blank;
        error      <= !dec_legal && !dec_blank;
        stable_cnt <= stable_next;
        locked     <= (stable_next >= STABLE_MAX);
        if (dec_legal) digit <= dec_digit;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader. Frames are synthesised by
// driving pixels around each probe square with a chosen number of lit pixels
// inside it; a frame-level model counts hits, votes, decodes and tracks the
// stability counter from the behavioural rules.
module tb_seven_segment_reader;

  localparam int PROBE  = 4;
  localparam int STABLE = 3;
  localparam int AREA   = PROBE * PROBE;
  localparam int TH     = AREA / 2 + 1;

  localparam int CX [7] = '{40, 70, 70, 40, 10, 10, 40};
  localparam int CY [7] = '{10, 40, 100, 130, 100, 40, 70};
  localparam logic [6:0] GLYPH [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sx = '0;
  logic [9:0] sy = '0;
  logic       de = 1'b0;
  logic       pixel_on = 1'b0;
  logic       frame_start = 1'b0;
  logic       frame_end = 1'b0;
  logic [6:0] seg_mask;
  logic [3:0] digit;
  logic       valid;
  logic       error;
  logic       blank;
  logic       locked;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         hits [7];
  int         kk [7];
  bit         model_scan;
  logic [6:0] exp_mask;
  logic [3:0] exp_digit;
  int         exp_stable;
  bit         exp_error;
  bit         exp_blank;
  bit         exp_locked;

  seven_segment_reader #(
    .X0     (0),
    .Y0     (0),
    .PROBE  (PROBE),
    .STABLE (STABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sx          (sx),
    .sy          (sy),
    .de          (de),
    .pixel_on    (pixel_on),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .seg_mask    (seg_mask),
    .digit       (digit),
    .valid       (valid),
    .error       (error),
    .blank       (blank),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic bit in_box(input int s, input int x, input int y);
    return (x >= CX[s] - PROBE / 2) && (x <= CX[s] + PROBE / 2 - 1) &&
           (y >= CY[s] - PROBE / 2) && (y <= CY[s] + PROBE / 2 - 1);
  endfunction

  task automatic reset_model();
    for (int s = 0; s < 7; s++) hits[s] = 0;
    model_scan = 0;
    exp_mask   = '0;
    exp_digit  = '0;
    exp_stable = 0;
    exp_error  = 0;
    exp_blank  = 0;
    exp_locked = 0;
  endtask

  task automatic clear_hits();
    for (int s = 0; s < 7; s++) hits[s] = 0;
  endtask

  // Lit segments get a clear majority, dark ones at most a minority
  task automatic make_counts(input logic [6:0] m);
    for (int s = 0; s < 7; s++)
      kk[s] = m[s] ? int'($urandom_range(TH, AREA)) : int'($urandom_range(0, TH - 1));
  endtask

  task automatic put_pixel(input int x, input int y, input logic d, input logic on);
    @(negedge clk);
    sx = 10'(x);
    sy = 10'(y);
    de = d;
    pixel_on = on;
    if (model_scan && d && on)
      for (int s = 0; s < 7; s++)
        if (in_box(s, x, y) && hits[s] < AREA) hits[s]++;
  endtask

  // Scan an 8x8 window around every probe; exactly kk[s] probe pixels are lit
  task automatic drive_pixels();
    int need, slots, x, y;
    logic on;
    for (int s = 0; s < 7; s++) begin
      need  = kk[s];
      slots = AREA;
      for (int dy = -4; dy < 4; dy++) begin
        for (int dx = -4; dx < 4; dx++) begin
          x = CX[s] + dx;
          y = CY[s] + dy;
          if (in_box(s, x, y)) begin
            on = (int'($urandom_range(1, slots)) <= need);
            if (on) need--;
            slots--;
          end else begin
            on = 1'($urandom_range(0, 1));
          end
          if ($urandom_range(0, 7) == 0) put_pixel(x, y, 1'b0, 1'b1);
          put_pixel(x, y, 1'b1, on);
        end
      end
    end
    for (int i = 0; i < 8; i++)
      put_pixel(int'($urandom_range(800, 1023)), int'($urandom_range(0, 1023)), 1'b1, 1'b1);
    @(negedge clk);
    de = 1'b0;
    pixel_on = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start = 1'b1;
    clear_hits();
    model_scan = 1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Frame-level decision rules applied to the model's hit counts
  task automatic model_decide();
    int d;
    d = -1;
    for (int s = 0; s < 7; s++) exp_mask[s] = (hits[s] >= TH);
    for (int n = 0; n < 10; n++) if (exp_mask == GLYPH[n]) d = n;
    if (exp_mask == 7'h00) begin
      exp_blank = 1; exp_error = 0; exp_stable = 0;
    end else if (d < 0) begin
      exp_blank = 0; exp_error = 1; exp_stable = 0;
    end else begin
      exp_blank = 0; exp_error = 0;
      if (4'(d) == exp_digit) exp_stable = (exp_stable >= STABLE) ? STABLE : exp_stable + 1;
      else exp_stable = 1;
      exp_digit = 4'(d);
    end
    exp_locked = (exp_stable >= STABLE);
  endtask

  // frame_end, then check publication exactly 2 clocks later
  task automatic end_frame(input string name, input bit start_with_end, input bit start_in_decide);
    @(negedge clk);
    frame_end   = 1'b1;
    frame_start = start_with_end;
    @(negedge clk);
    frame_end   = 1'b0;
    frame_start = start_in_decide;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_valid: got %b expected 0", name, valid);
    end
    model_decide();
    if (start_with_end || start_in_decide) begin
      clear_hits();
      model_scan = 1;
    end else begin
      model_scan = 0;
    end
    @(negedge clk);
    frame_start = 1'b0;
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b expected 1", name, valid);
    end
    checks++;
    if (seg_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s seg_mask: got %h expected %h", name, seg_mask, exp_mask);
    end
    checks++;
    if (digit !== exp_digit) begin
      errors++;
      $display("FAIL %s digit: got %0d expected %0d", name, digit, exp_digit);
    end
    checks++;
    if (error !== exp_error) begin
      errors++;
      $display("FAIL %s error: got %b expected %b", name, error, exp_error);
    end
    checks++;
    if (blank !== exp_blank) begin
      errors++;
      $display("FAIL %s blank: got %b expected %b", name, blank, exp_blank);
    end
    checks++;
    if (locked !== exp_locked) begin
      errors++;
      $display("FAIL %s locked: got %b expected %b", name, locked, exp_locked);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_pulse: got %b expected 0 one cycle later", name, valid);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({seg_mask, digit, valid, error, blank, locked} !== 15'h0) begin
      errors++;
      $display("FAIL %s outputs: got mask=%h digit=%0d valid=%b error=%b blank=%b locked=%b expected all 0",
               name, seg_mask, digit, valid, error, blank, locked);
    end
  endtask

  task automatic test_reset();
    reset_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
  endtask

  task automatic test_digit8();
    for (int s = 0; s < 7; s++) kk[s] = AREA;
    pulse_start();
    drive_pixels();
    end_frame("digit8", 0, 0);
  endtask

  // Digits 0..9, one per frame, frames back to back via start during DECIDE
  task automatic test_sweep();
    pulse_start();
    for (int n = 0; n < 10; n++) begin
      make_counts(GLYPH[n]);
      drive_pixels();
      end_frame($sformatf("sweep%0d", n), 0, (n < 9));
    end
  endtask

  task automatic test_illegal();
    make_counts(7'h12);
    pulse_start();
    drive_pixels();
    end_frame("illegal", 0, 0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL illegal locked: got %b expected 0", locked);
    end
  endtask

  task automatic test_lock();
    for (int f = 0; f < 3; f++) begin
      make_counts(GLYPH[4]);
      pulse_start();
      drive_pixels();
      end_frame($sformatf("lock4_%0d", f), 0, 0);
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_third locked: got %b expected 1", locked);
    end
    make_counts(GLYPH[5]);
    pulse_start();
    drive_pixels();
    end_frame("lock5", 0, 0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_switch locked: got %b expected 0", locked);
    end
  endtask

  // Segment a at one below and exactly at the majority threshold
  task automatic test_threshold();
    for (int a = TH - 1; a <= TH; a++) begin
      make_counts(7'h07);
      kk[0] = a;
      pulse_start();
      drive_pixels();
      end_frame($sformatf("thresh%0d", a), 0, 0);
      checks++;
      if (seg_mask[0] !== (a >= TH)) begin
        errors++;
        $display("FAIL thresh%0d bit_a: got %b expected %b", a, seg_mask[0], (a >= TH));
      end
    end
  endtask

  // frame_start inside SCAN discards the counts gathered so far
  task automatic test_restart();
    make_counts(GLYPH[8]);
    pulse_start();
    drive_pixels();
    make_counts(GLYPH[1]);
    pulse_start();
    drive_pixels();
    end_frame("restart", 0, 0);
  endtask

  task automatic test_start_end_same_then_rst();
    int vcount;
    make_counts(GLYPH[3]);
    pulse_start();
    drive_pixels();
    end_frame("same_cycle", 1, 0);
    make_counts(GLYPH[8]);
    drive_pixels();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_frame");
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(negedge clk);
    check_all_zero("rst_released");
    drive_pixels();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL idle_frame_end valids: got %0d expected 0", vcount);
    end
    make_counts(GLYPH[2]);
    pulse_start();
    drive_pixels();
    end_frame("after_rst", 0, 0);
  endtask

  initial begin
    test_reset();
    test_digit8();
    test_sweep();
    test_illegal();
    test_lock();
    test_threshold();
    test_restart();
    test_start_end_same_then_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
